// File: rtl/channel_in_partial_sum_acc.sv
// Channel-in partial-sum accumulator: sums N beats per lane, queues results in a 2-entry FIFO.
// Optional macro ACC_SATURATE_EN selects saturating lane adds (default: wrap).
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 4
`endif

module channel_in_partial_sum_acc #(
  parameter int ITER_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [ITER_W-1:0]                         iter_num,
  input  logic [ITER_W-1:0]                         out_num,
  input  logic                                      data_in_valid,
  input  logic [`PICTURE_NUM*`WIDTH_DATA_OUT*2-1:0] data_in,
  output logic [`PICTURE_NUM*`WIDTH_DATA_OUT*2-1:0] data_out,
  output logic                                      data_out_valid,
  input  logic                                      data_out_ready,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      drop_err
);

  localparam int L = `WIDTH_DATA_OUT * 2;
  localparam int P = `PICTURE_NUM;
  localparam int W = P * L;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  logic [ITER_W-1:0] n_lat;
  logic [ITER_W-1:0] m_lat;
  logic [ITER_W-1:0] beat_cnt;
  logic [ITER_W-1:0] out_cnt;
  logic [W-1:0]      acc;
  logic [W-1:0]      tail;
  logic              tail_valid;

  logic [ITER_W-1:0] n_eff;
  logic [ITER_W-1:0] m_eff;
  logic [ITER_W-1:0] bc;
  logic [ITER_W-1:0] oc;
  logic              beat;
  logic              last;
  logic              job_end;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;
  logic [W-1:0]      sum;

  // One lane add; the lane is isolated so no carry leaks to its neighbour.
  function automatic logic [L-1:0] lane_add(
    input logic [L-1:0] a,
    input logic [L-1:0] b
  );
`ifdef ACC_SATURATE_EN
    logic [L:0] s;
    s = {a[L-1], a} + {b[L-1], b};
    if (s[L] != s[L-1])
      lane_add = s[L] ? {1'b1, {(L-1){1'b0}}}
                      : {1'b0, {(L-1){1'b1}}};
    else
      lane_add = s[L-1:0];
`else
    lane_add = a + b;
`endif
  endfunction

  // Effective job parameters and counters; a start restarts them this cycle.
  always_comb begin
    n_eff = n_lat;
    m_eff = m_lat;
    bc    = beat_cnt;
    oc    = out_cnt;
    if (start) begin
      n_eff = (iter_num == '0) ? ITER_W'(1) : iter_num;
      m_eff = (out_num == '0) ? ITER_W'(1) : out_num;
      bc    = '0;
      oc    = '0;
    end
    beat    = data_in_valid & (start | (state == RUN));
    last    = beat & (bc == n_eff - ITER_W'(1));
    job_end = last &
              (({1'b0, oc} + (ITER_W+1)'(1)) == {1'b0, m_eff});
  end

  // Beat 0 loads the input, later beats add lane by lane.
  always_comb begin
    sum = data_in;
    if (bc != '0) begin
      for (int i = 0; i < P; i++)
        sum[i*L +: L] = lane_add(acc[i*L +: L], data_in[i*L +: L]);
    end
  end

  assign push = last;
  assign pop  = data_out_valid & data_out_ready;
  assign full = data_out_valid & tail_valid;
  assign drop = push & full & ~pop;

  // Job control FSM: counters, accumulator, busy/done/drop_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop_err <= 1'b0;
      n_lat    <= '0;
      m_lat    <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        n_lat <= n_eff;
        m_lat <= m_eff;
      end
      if (start || state == RUN) begin
        if (beat) begin
          acc      <= sum;
          beat_cnt <= last ? '0 : bc + ITER_W'(1);
        end else if (start) begin
          acc      <= '0;
          beat_cnt <= '0;
        end
        if (last)
          out_cnt <= oc + ITER_W'(1);
        else if (start)
          out_cnt <= '0;
        state <= job_end ? DRAIN : RUN;
        busy  <= 1'b1;
      end else if (state == DRAIN && !data_out_valid) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
      if (start)
        drop_err <= drop;
      else if (drop)
        drop_err <= 1'b1;
    end
  end

  // Two-entry output FIFO; data_out is the registered head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      tail           <= '0;
      tail_valid     <= 1'b0;
    end else if (!data_out_valid) begin
      if (push) begin
        data_out       <= sum;
        data_out_valid <= 1'b1;
      end
    end else if (!tail_valid) begin
      if (pop && push) begin
        data_out <= sum;
      end else if (pop) begin
        data_out_valid <= 1'b0;
      end else if (push) begin
        tail       <= sum;
        tail_valid <= 1'b1;
      end
    end else if (pop) begin
      data_out <= tail;
      if (push)
        tail <= sum;
      else
        tail_valid <= 1'b0;
    end
  end

endmodule
